// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot loader: receives a framed image over the UART byte stream,
// writes it word by word into instruction RAM, then releases the CPU and hands it the address port.
module imem_boot_ctrl #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          TIMEOUT    = 100000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  reload,
    input  logic [31:0]           cpu_pc,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int          TW  = $clog2(TIMEOUT + 1);
    localparam logic [16:0] CAP = 17'(1 << ADDR_WIDTH);

    // rx_valid is a one-cycle strobe with no back-pressure: every strobe carries one byte.
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_RUN, S_ERROR
    } state_t;

    state_t                state, next_state;
    logic [15:0]           len;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [1:0]            byte_cnt;
    logic [31:0]           asm_word;
    logic [7:0]            chk;
    logic [TW-1:0]         tmo;
    logic                  active, tmo_hit, last_word, chk_slot;
    logic [16:0]           len_new;
    logic                  pc_unused;

    assign pc_unused = ^{cpu_pc[31:ADDR_WIDTH+2], cpu_pc[1:0]};

    always_comb begin
        active    = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHECK);
        len_new   = {1'b0, len[15:8], rx_data};
        last_word = (17'(word_cnt) == ({1'b0, len} - 17'd1));
        // Write cycle of the final word: a byte arriving now is already the checksum.
        chk_slot  = mem_we && last_word;
        tmo_hit   = active && !rx_valid && (tmo == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) next_state = S_LEN_HI;
            S_LEN_HI: begin
                if (rx_valid)     next_state = S_LEN_LO;
                else if (tmo_hit) next_state = S_ERROR;
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    if (len_new > CAP)        next_state = S_ERROR;
                    else if (len_new == '0)   next_state = S_CHECK;
                    else                      next_state = S_DATA;
                end else if (tmo_hit) begin
                    next_state = S_ERROR;
                end
            end
            S_DATA: begin
                if (chk_slot) begin
                    if (rx_valid) next_state = (rx_data == chk) ? S_RUN : S_ERROR;
                    else          next_state = S_CHECK;
                end else if (tmo_hit) begin
                    next_state = S_ERROR;
                end
            end
            S_CHECK: begin
                if (rx_valid)     next_state = (rx_data == chk) ? S_RUN : S_ERROR;
                else if (tmo_hit) next_state = S_ERROR;
            end
            S_RUN:   if (reload) next_state = S_IDLE;
            S_ERROR: if (rx_valid && rx_data == SYNC_BYTE) next_state = S_LEN_HI;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            chk       <= '0;
            tmo       <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            tmo    <= (active && !rx_valid && !tmo_hit) ? tmo + 1'b1 : '0;
            if (next_state == S_LEN_HI && state != S_LEN_HI) begin
                chk      <= '0;
                byte_cnt <= '0;
                word_cnt <= '0;
            end
            case (state)
                S_LEN_HI: if (rx_valid) len[15:8] <= rx_data;
                S_LEN_LO: if (rx_valid) len[7:0]  <= rx_data;
                S_DATA: begin
                    // Counter holds at N-1 after the final write, so a full memory never wraps.
                    if (mem_we && !last_word) word_cnt <= word_cnt + 1'b1;
                    if (rx_valid && !chk_slot) begin
                        asm_word <= {asm_word[23:0], rx_data};
                        chk      <= chk ^ rx_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {asm_word[23:0], rx_data};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_reset  = (state != S_RUN);
        load_done  = (state == S_RUN);
        load_error = (state == S_ERROR);
        mem_addr   = (state == S_RUN) ? cpu_pc[ADDR_WIDTH+1:2] : word_cnt;
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: hand-written corner sequences plus a table of randomized frames
// whose expected writes and outcome come from a byte-level frame model.
module tb_imem_boot_ctrl;

    localparam int AW  = 8;
    localparam int TO  = 40;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, rx_valid, reload;
    logic [7:0]    rx_data;
    logic [31:0]   cpu_pc;
    logic [AW-1:0] mem_addr;
    logic          mem_we, cpu_reset, load_done, load_error;
    logic [31:0]   mem_wdata;

    imem_boot_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .reload(reload), .cpu_pc(cpu_pc), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int wr_seen = 0;
    logic [AW+31:0] exp_q[$];
    logic [31:0]    frame_words[0:CAP-1];

    typedef struct {
        int n;
        bit bad_chk;
        bit exp_done;
        bit exp_err;
        int exp_writes;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
        tick(gap);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick(1);
        reload = 1'b0;
    endtask

    // Frame model: header, payload MSB first, XOR checksum (optionally corrupted by flip).
    task automatic send_frame(input int n, input logic [7:0] flip, input int gap_max);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [15:0] nn;
        x  = 8'h00;
        nn = 16'(n);
        send_byte(8'hA5, $urandom_range(0, gap_max));
        send_byte(nn[15:8], $urandom_range(0, gap_max));
        send_byte(nn[7:0], $urandom_range(0, gap_max));
        if (n <= CAP) begin
            for (int w = 0; w < n; w++) begin
                exp_q.push_back({AW'(w), frame_words[w]});
                for (int k = 0; k < 4; k++) begin
                    b = 8'(frame_words[w] >> (24 - 8 * k));
                    x ^= b;
                    send_byte(b, $urandom_range(0, gap_max));
                end
            end
            send_byte(x ^ flip, 0);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && mem_we === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL write: unexpected write addr %0h data %0h", mem_addr, mem_wdata);
            end else begin
                check("write", {24'h0, mem_addr, mem_wdata}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int w0;
        logic [7:0] junk;
        vecs[0] = '{1,   1'b0, 1'b1, 1'b0, 1};
        vecs[1] = '{4,   1'b1, 1'b0, 1'b1, 4};
        vecs[2] = '{0,   1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{0,   1'b1, 1'b0, 1'b1, 0};
        vecs[4] = '{300, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{256, 1'b0, 1'b1, 1'b0, 256};
        vecs[6] = '{257, 1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{7,   1'b0, 1'b1, 1'b0, 7};

        reset = 1'b1; rx_valid = 1'b0; reload = 1'b0; rx_data = 8'h00; cpu_pc = 32'h0;
        tick(3);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_error", load_error, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        tick(1);

        // Known two-word image, checksum 0x17.
        frame_words[0] = 32'h20040005;
        frame_words[1] = 32'h00001026;
        w0 = wr_seen;
        send_frame(2, 8'h00, 0);
        tick(2);
        check("t1_writes", wr_seen - w0, 2);
        check("t1_load_done", load_done, 1);
        check("t1_cpu_reset", cpu_reset, 0);
        cpu_pc = 32'h4;
        #1;
        check("t1_pc_addr", mem_addr, 1);

        // Same image with CHK=0x00.
        pulse_reload();
        w0 = wr_seen;
        send_frame(2, 8'h17, 1);
        tick(2);
        check("t2_writes", wr_seen - w0, 2);
        check("t2_load_error", load_error, 1);
        check("t2_cpu_reset", cpu_reset, 1);
        send_frame(2, 8'h00, 1);
        tick(2);
        check("t2_recover_done", load_done, 1);
        check("t2_recover_err", load_error, 0);

        // reload together with a sync byte: reload wins, byte dropped.
        reload = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
        tick(1);
        reload = 1'b0; rx_valid = 1'b0;
        check("t5_cpu_reset", cpu_reset, 1);
        check("t5_load_done", load_done, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        tick(2);
        check("t5_dropped_done", load_done, 0);
        check("t5_dropped_err", load_error, 0);
        w0 = wr_seen;
        send_frame(0, 8'h00, 1);
        tick(2);
        check("t3_empty_done", load_done, 1);
        check("t3_empty_writes", wr_seen - w0, 0);

        // Oversized length aborts straight after LEN_LO.
        pulse_reload();
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
        check("t3_oversize_err", load_error, 1);
        check("t3_oversize_writes", wr_seen - w0, 0);

        // Stall after two payload bytes.
        w0 = wr_seen;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 1);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        tick(TO - 1);
        check("t4_before_timeout", load_error, 0);
        tick(1);
        check("t4_at_timeout", load_error, 1);
        check("t4_writes", wr_seen - w0, 0);

        // Reset mid-DATA after one full word.
        w0 = wr_seen;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
        exp_q.push_back({AW'(0), 32'h11223344});
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 2);
        reset = 1'b1;
        tick(1);
        check("t6_cpu_reset", cpu_reset, 1);
        check("t6_mem_we", mem_we, 0);
        check("t6_mem_wdata", mem_wdata, 0);
        check("t6_load_done", load_done, 0);
        check("t6_load_error", load_error, 0);
        check("t6_mem_addr", mem_addr, 0);
        reset = 1'b0;
        send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
        tick(3);
        check("t6_writes", wr_seen - w0, 1);
        check("t6_queue", exp_q.size(), 0);

        for (int i = 0; i < 8; i++) begin
            if (load_done) pulse_reload();
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h00;
            send_byte(junk, 1);
            for (int w = 0; w < CAP; w++) frame_words[w] = $urandom;
            w0 = wr_seen;
            send_frame(vecs[i].n, vecs[i].bad_chk ? 8'($urandom_range(1, 255)) : 8'h00, 2);
            tick(3);
            check($sformatf("v%0d_done", i), load_done, vecs[i].exp_done);
            check($sformatf("v%0d_err", i), load_error, vecs[i].exp_err);
            check($sformatf("v%0d_cpu_reset", i), cpu_reset, !vecs[i].exp_done);
            check($sformatf("v%0d_writes", i), wr_seen - w0, vecs[i].exp_writes);
            check($sformatf("v%0d_queue", i), exp_q.size(), 0);
            if (vecs[i].exp_done) begin
                cpu_pc = $urandom;
                #1;
                check($sformatf("v%0d_pc_addr", i), mem_addr, (cpu_pc >> 2) % CAP);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
